// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and message-length lookup.
package midi_pkg;

  localparam logic [7:0] ST_NOTE_OFF = 8'h80;
  localparam logic [7:0] ST_NOTE_ON  = 8'h90;
  localparam logic [7:0] ST_POLY_AT  = 8'hA0;
  localparam logic [7:0] ST_CTRL     = 8'hB0;
  localparam logic [7:0] ST_PROG     = 8'hC0;
  localparam logic [7:0] ST_CHAN_AT  = 8'hD0;
  localparam logic [7:0] ST_PITCH    = 8'hE0;
  localparam logic [7:0] ST_SYSEX    = 8'hF0;
  localparam logic [7:0] ST_EOX      = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {IDLE, CHAN, SYSCOM, SYSEX} parser_state_t;

  // Realtime bytes may appear anywhere and never disturb message state.
  function automatic logic is_realtime(input logic [7:0] b);
    return b >= RT_MIN;
  endfunction

  // Channel-voice status 0x80..0xEF.
  function automatic logic is_channel(input logic [7:0] b);
    return b[7] && (b < ST_SYSEX);
  endfunction

  // Number of data bytes following a status byte. Program change and
  // channel aftertouch (0xC0-0xDF) carry one; other channel messages two.
  // Undefined / parameterless system-common bytes carry none.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status < ST_SYSEX) begin
      len = (status[7:5] == 3'b110) ? 2'd1 : 2'd2;
    end else begin
      case (status)
        8'hF1, 8'hF3: len = 2'd1;
        8'hF2:        len = 2'd2;
        default:      len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI stream parser: running status, data-byte numbering, realtime
// interleave, sysex framing and system-common handling. All outputs are
// registered and respond one cycle after rx_valid.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int SYSEX_MAX   = 255,
  parameter bit CHECK_FRAME = 1'b1
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_frame_err,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midibyte,
  output logic       msg_done,
  output logic       sys_real,
  output logic [7:0] sys_real_dat,
  output logic       sysex_active,
  output logic       rx_err
);

  localparam logic [7:0] NR_SAT = 8'(SYSEX_MAX);

  parser_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [7:0]    cur_status_d, nr_d, midibyte_d, sys_real_dat_d;
  logic          byteready_d, msg_done_d, sys_real_d, sysex_d, rx_err_d;

  // In CHAN a complete message wraps the count for running status.
  assign cnt_inc = (cnt_q == len_q) ? 2'd1 : cnt_q + 2'd1;

  // Next-state and next-output decode for one received byte.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    cur_status_d   = cur_status;
    nr_d           = midibyte_nr;
    midibyte_d     = midibyte;
    sys_real_dat_d = sys_real_dat;
    sysex_d        = sysex_active;
    byteready_d    = 1'b0;
    msg_done_d     = 1'b0;
    sys_real_d     = 1'b0;
    rx_err_d       = 1'b0;
    if (rx_valid) begin
      if (CHECK_FRAME && rx_frame_err) begin
        rx_err_d = 1'b1;
      end else if (is_realtime(rx_byte)) begin
        sys_real_d     = 1'b1;
        sys_real_dat_d = rx_byte;
      end else if (rx_byte[7]) begin
        // Any status byte starts a new message and abandons a partial one.
        byteready_d  = 1'b1;
        midibyte_d   = rx_byte;
        cur_status_d = rx_byte;
        nr_d         = 8'd0;
        cnt_d        = 2'd0;
        len_d        = msg_len(rx_byte);
        if (rx_byte == ST_EOX && state_q == SYSEX) begin
          msg_done_d = 1'b1;
          sysex_d    = 1'b0;
          state_d    = IDLE;
        end else if (rx_byte == ST_SYSEX) begin
          sysex_d = 1'b1;
          state_d = SYSEX;
        end else begin
          sysex_d = 1'b0;
          if (msg_len(rx_byte) == 2'd0) begin
            msg_done_d = 1'b1;
            state_d    = IDLE;
          end else if (is_channel(rx_byte)) begin
            state_d = CHAN;
          end else begin
            state_d = SYSCOM;
          end
        end
      end else begin
        case (state_q)
          IDLE: rx_err_d = 1'b1;
          CHAN: begin
            byteready_d = 1'b1;
            midibyte_d  = rx_byte;
            cnt_d       = cnt_inc;
            nr_d        = {6'd0, cnt_inc};
            msg_done_d  = (cnt_inc == len_q);
          end
          SYSCOM: begin
            if (cnt_q < len_q) begin
              byteready_d = 1'b1;
              midibyte_d  = rx_byte;
              cnt_d       = cnt_q + 2'd1;
              nr_d        = {6'd0, cnt_q + 2'd1};
              msg_done_d  = ((cnt_q + 2'd1) == len_q);
            end else begin
              // System common has no running status: surplus data is orphaned.
              rx_err_d     = 1'b1;
              state_d      = IDLE;
              cur_status_d = 8'h00;
            end
          end
          default: begin
            byteready_d = 1'b1;
            midibyte_d  = rx_byte;
            nr_d        = (midibyte_nr >= NR_SAT) ? midibyte_nr : midibyte_nr + 8'd1;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      len_q        <= 2'd0;
      cur_status   <= 8'h00;
      midibyte_nr  <= 8'd0;
      midibyte     <= 8'h00;
      sys_real_dat <= 8'h00;
      sysex_active <= 1'b0;
      byteready    <= 1'b0;
      msg_done     <= 1'b0;
      sys_real     <= 1'b0;
      rx_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      cur_status   <= cur_status_d;
      midibyte_nr  <= nr_d;
      midibyte     <= midibyte_d;
      sys_real_dat <= sys_real_dat_d;
      sysex_active <= sysex_d;
      byteready    <= byteready_d;
      msg_done     <= msg_done_d;
      sys_real     <= sys_real_d;
      rx_err       <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Bench for midi_byte_parser: message-level reference model compared every
// cycle, plus literal expectations on selected bytes.
module tb_midi_byte_parser;

  logic       CLOCK_25 = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_frame_err = 1'b0;
  logic       byteready, msg_done, sys_real, sysex_active, rx_err;
  logic [7:0] cur_status, midibyte_nr, midibyte, sys_real_dat;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  midi_byte_parser #(.SYSEX_MAX(255), .CHECK_FRAME(1'b1)) dut (
    .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_frame_err(rx_frame_err), .byteready(byteready),
    .cur_status(cur_status), .midibyte_nr(midibyte_nr), .midibyte(midibyte),
    .msg_done(msg_done), .sys_real(sys_real), .sys_real_dat(sys_real_dat),
    .sysex_active(sysex_active), .rx_err(rx_err)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  // Reference model: mode 0 = no message open, 1 = channel message,
  // 2 = system common, 3 = inside sysex.
  int         m_mode, m_need, m_got;
  logic       e_br, e_done, e_sr, e_err;
  logic [7:0] e_cs, e_nr, e_mb, e_srd;

  function automatic int data_count(input logic [7:0] s);
    int n;
    if (s < 8'hF0) n = (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 1 : 2;
    else if (s == 8'hF1 || s == 8'hF3) n = 1;
    else if (s == 8'hF2) n = 2;
    else n = 0;
    return n;
  endfunction

  // Model update on each clock, from the byte presented that cycle.
  always @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      m_mode = 0; m_need = 0; m_got = 0;
      e_br = 0; e_done = 0; e_sr = 0; e_err = 0;
      e_cs = 0; e_nr = 0; e_mb = 0; e_srd = 0;
    end else begin
      e_br = 0; e_done = 0; e_sr = 0; e_err = 0;
      if (rx_valid) begin
        if (rx_frame_err) e_err = 1;
        else if (rx_byte >= 8'hF8) begin
          e_sr = 1; e_srd = rx_byte;
        end else if (rx_byte >= 8'h80) begin
          e_br = 1; e_cs = rx_byte; e_nr = 0; e_mb = rx_byte; m_got = 0;
          m_need = data_count(rx_byte);
          if (rx_byte == 8'hF7 && m_mode == 3) begin
            e_done = 1; m_mode = 0;
          end else if (rx_byte == 8'hF0) m_mode = 3;
          else if (m_need == 0) begin
            e_done = 1; m_mode = 0;
          end else m_mode = (rx_byte < 8'hF0) ? 1 : 2;
        end else if (m_mode == 0) e_err = 1;
        else if (m_mode == 3) begin
          e_br = 1; e_mb = rx_byte;
          if (e_nr != 8'd255) e_nr = e_nr + 1;
        end else if (m_mode == 2 && m_got == m_need) begin
          e_err = 1; m_mode = 0; e_cs = 0;
        end else begin
          if (m_got == m_need) m_got = 0;
          m_got = m_got + 1;
          e_br = 1; e_mb = rx_byte; e_nr = 8'(m_got);
          e_done = (m_got == m_need);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLOCK_25) begin
    if (cmp_en) begin
      n_chk++;
      if ({byteready, cur_status, midibyte_nr, midibyte, msg_done, sys_real,
           sys_real_dat, sysex_active, rx_err} !==
          {e_br, e_cs, e_nr, e_mb, e_done, e_sr, e_srd, (m_mode == 3), e_err}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: got br=%b cs=%h nr=%0d mb=%h done=%b sr=%b srd=%h sx=%b err=%b; want br=%b cs=%h nr=%0d mb=%h done=%b sr=%b srd=%h sx=%b err=%b",
                 $time, byteready, cur_status, midibyte_nr, midibyte, msg_done, sys_real,
                 sys_real_dat, sysex_active, rx_err, e_br, e_cs, e_nr, e_mb, e_done,
                 e_sr, e_srd, (m_mode == 3), e_err);
      end
    end
  end

  task automatic lit(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe = 1'b0);
    @(negedge CLOCK_25);
    rx_valid = 1'b1; rx_byte = b; rx_frame_err = fe;
  endtask

  task automatic idle();
    @(negedge CLOCK_25);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  // Wait until the byte just driven has been registered.
  task automatic settle();
    @(posedge CLOCK_25); #1;
  endtask

  initial begin
    repeat (2) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    lit("reset_outputs", {1'b0, byteready | msg_done | sys_real | sysex_active | rx_err,
        cur_status | midibyte_nr | midibyte | sys_real_dat}, 9'h0);
    @(posedge CLOCK_25); #2 reset_reg_N = 1'b1;
    cmp_en = 1'b1;

    send(8'h45); settle();
    lit("orphan_err", {8'h0, rx_err}, 9'h1);
    lit("orphan_no_br", {8'h0, byteready}, 9'h0);
    send(8'h90, 1'b1); settle();
    lit("frame_err", {8'h0, rx_err}, 9'h1);
    lit("frame_cs", {1'b0, cur_status}, 9'h00);

    send(8'h90); settle(); lit("note_nr0", {1'b0, midibyte_nr}, 9'd0);
    send(8'h3C); settle(); lit("note_done_early", {8'h0, msg_done}, 9'h0);
    send(8'h64); settle();
    lit("note_nr2", {1'b0, midibyte_nr}, 9'd2);
    lit("note_done", {8'h0, msg_done}, 9'h1);
    lit("note_cs", {1'b0, cur_status}, 9'h90);
    send(8'h40); settle(); lit("run_nr1", {1'b0, midibyte_nr}, 9'd1);
    send(8'h00); settle();
    lit("run_done", {8'h0, msg_done}, 9'h1);
    lit("run_cs", {1'b0, cur_status}, 9'h90);
    idle();

    send(8'h90); send(8'h3C); send(8'hF8); settle();
    lit("rt_pulse", {8'h0, sys_real}, 9'h1);
    lit("rt_dat", {1'b0, sys_real_dat}, 9'hF8);
    lit("rt_no_br", {8'h0, byteready}, 9'h0);
    send(8'h64); settle();
    lit("rt_nr2", {1'b0, midibyte_nr}, 9'd2);
    lit("rt_done", {8'h0, msg_done}, 9'h1);

    send(8'hC5); send(8'h07); settle();
    lit("prog_done1", {msg_done, midibyte_nr}, {1'b1, 8'd1});
    send(8'h09); settle();
    lit("prog_done2", {msg_done, midibyte_nr}, {1'b1, 8'd1});
    idle();

    send(8'hF0); settle(); lit("sx_on", {8'h0, sysex_active}, 9'h1);
    for (int i = 0; i < 300; i++) send(8'(i & 8'h7F));
    settle();
    lit("sx_sat", {sysex_active, midibyte_nr}, {1'b1, 8'd255});
    send(8'hF7); settle();
    lit("eox_cs", {1'b0, cur_status}, 9'hF7);
    lit("eox_done_sx", {7'h0, msg_done, sysex_active}, 9'b10);
    send(8'h10); settle();
    lit("post_eox", {7'h0, rx_err, byteready}, 9'b10);
    idle();

    send(8'hF2); send(8'h01); send(8'h02); settle();
    lit("spp_done", {msg_done, midibyte_nr}, {1'b1, 8'd2});
    send(8'h03); settle();
    lit("spp_extra", {rx_err, cur_status}, {1'b1, 8'h00});

    send(8'h90); send(8'h3C); send(8'hB0); settle();
    lit("abort", {msg_done, cur_status}, {1'b0, 8'hB0});
    send(8'hF0); send(8'h11); send(8'h90); settle();
    lit("sx_abort", {sysex_active, cur_status}, {1'b0, 8'h90});

    send(8'h3C); idle();
    @(posedge CLOCK_25); #2 reset_reg_N = 1'b0;
    @(negedge CLOCK_25);
    lit("mid_reset", {1'b0, cur_status}, 9'h00);
    @(posedge CLOCK_25); #2 reset_reg_N = 1'b1;
    send(8'h40); settle();
    lit("post_reset_orphan", {7'h0, rx_err, byteready}, 9'b10);
    idle();
    repeat (3) @(negedge CLOCK_25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_byte_parser.md
Name: midi_byte_parser

Overview:
- Sits between the MIDI UART receiver and midi_decoder, in the CLOCK_25 domain.
- Consumes raw received bytes and applies MIDI stream semantics:
  - running status
  - data-byte numbering
  - realtime interleave
  - sysex framing
  - system-common handling
- Produces the byteready / cur_status / midibyte_nr / midibyte / sys_real / sys_real_dat interface that midi_decoder consumes.

Parameters:
- SYSEX_MAX, 255: saturation value of midibyte_nr during sysex.
- CHECK_FRAME, 1: when 1, bytes flagged with rx_frame_err are dropped; when 0, the flag is ignored.

Ports:
- CLOCK_25  in  1  system clock.
- reset_reg_N  in  1  asynchronous active-low reset.
- rx_valid  in  1  single-cycle strobe: rx_byte holds a new received byte.
- rx_byte  in  8  received byte.
- rx_frame_err  in  1  stop-bit error for the byte qualified by rx_valid.
- byteready  out  1  single-cycle pulse: a non-realtime byte was accepted.
- cur_status  out  8  current status byte; 0x00 = no valid status.
- midibyte_nr  out  8  position of midibyte in its message; 0 = the status byte itself.
- midibyte  out  8  accepted byte.
- msg_done  out  1  single-cycle pulse, coincident with the byteready of the last byte of a complete message.
- sys_real  out  1  single-cycle pulse: realtime byte (0xF8-0xFF) received.
- sys_real_dat  out  8  realtime byte value; holds until the next realtime byte.
- sysex_active  out  1  high from 0xF0 until 0xF7 or an aborting status.
- rx_err  out  1  single-cycle pulse: byte dropped (frame error, or orphan data byte).

Behaviour:
- Reset:
  - All outputs 0.
  - cur_status = 0x00 (no running status); state = IDLE; expected length = 0.
- Latency:
  - Every output responds exactly 1 cycle after the rx_valid cycle; all outputs are registered.
  - At most one byte per cycle.
  - rx_valid on consecutive cycles must be handled with no loss.
- Classification, per accepted byte (b = rx_byte):
  - Frame error (CHECK_FRAME=1, rx_frame_err=1): drop the byte, pulse rx_err, leave state untouched.
  - Realtime (b >= 0xF8): pulse sys_real, load sys_real_dat. No byteready. State, count and cur_status are unchanged, including mid-message and mid-sysex.
  - Channel status (0x80-0xEF):
    - cur_status = b, midibyte_nr = 0, midibyte = b, byteready pulse; state -> CHAN.
    - Expected length is 1 for 0xC0-0xDF and 2 otherwise.
    - Clears sysex_active if set (aborted sysex; no msg_done for the sysex).
  - Sysex start (0xF0): cur_status = 0xF0, nr = 0, byteready, sysex_active = 1; state -> SYSEX.
  - Sysex end (0xF7):
    - In SYSEX: cur_status = 0xF7, nr = 0, byteready, msg_done, sysex_active = 0; state -> IDLE with no running status.
    - Elsewhere: treated like an undefined system-common byte (see 0xF4/0xF5 below).
  - System common (0xF1-0xF6):
    - cur_status = b, nr = 0, byteready; running status cancelled.
    - Expected length: 0xF1 = 1, 0xF3 = 1, 0xF2 = 2, 0xF6 = 0.
    - 0xF4/0xF5 are undefined: length 0.
    - Length 0: msg_done fires in the same cycle as byteready, then state -> IDLE.
    - Otherwise state -> SYSCOM.
  - Data byte (b < 0x80):
    - IDLE: drop, pulse rx_err.
    - CHAN/SYSCOM, cnt < len: cnt += 1, midibyte_nr = cnt, byteready. When cnt reaches len, msg_done fires.
    - CHAN at cnt == len (running status): cnt restarts at 1; nr = 1, byteready, cur_status unchanged. For len=1, msg_done fires again.
    - SYSCOM at cnt == len: drop, pulse rx_err, state -> IDLE, cur_status = 0x00.
    - SYSEX: nr increments, saturating at SYSEX_MAX; byteready on every byte.
- State machine:
  - States: IDLE, CHAN, SYSCOM, SYSEX.
  - The internal 2-bit counter cnt and 2-bit len are separate from the 8-bit midibyte_nr register.
- Boundaries:
  - A status byte mid-message aborts the partial message: no msg_done for it, and the new message starts.
  - Reset asserted mid-message: immediate return to reset values; the first data byte after reset is orphaned (rx_err).
  - The sysex count does not wrap.

Decomposition:
- Add to shared package midi_pkg:
  - Constants ST_NOTE_OFF through ST_PITCH, ST_SYSEX = 8'hF0, ST_EOX = 8'hF7, RT_MIN = 8'hF8.
  - typedef enum logic [1:0] parser_state_t {IDLE, CHAN, SYSCOM, SYSEX}.
  - Function msg_len(status) returning 0..2.
- No sub-module: classification is a package function, and the FSM plus counters stay in one module.

Test Plan:
- Reset, then 0x90 0x3C 0x64:
  - byteready x3 with nr 0,1,2.
  - cur_status = 0x90; msg_done on the 0x64 cycle only.
- Running status: 0x90 0x3C 0x64 0x40 0x00 -> the last two bytes give nr 1,2, cur_status stays 0x90, second msg_done fires.
- Realtime interleave: 0x90 0x3C 0xF8 0x64 on consecutive cycles:
  - sys_real pulse with sys_real_dat = 0xF8.
  - No byteready on the 0xF8 cycle.
  - 0x64 still arrives as nr = 2 with msg_done.
- Program change: 0xC5 0x07 0x09 -> nr 0,1,1; msg_done on both data bytes.
- Sysex: 0xF0, then 300 data bytes, then 0xF7:
  - sysex_active high throughout; nr saturates at 255.
  - 0xF7 gives cur_status = 0xF7, msg_done, sysex_active = 0.
  - A following 0x10 gives rx_err and no byteready.
- Errors:
  - 0x45 straight after reset -> rx_err, no byteready.
  - 0x90 sent with rx_frame_err = 1 -> dropped; cur_status stays 0x00.
  - 0xF2 0x01 0x02 0x03 -> msg_done on 0x02; rx_err on 0x03; cur_status = 0x00.
